// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle for aes_round_ctrl.
//   in_valid / in_ready   : plaintext block handshake from the core input side
//   reg_full              : state register holds a written block
//   reg_wr_en             : state register write enable (single-cycle pulses)
//   sel_input             : datapath mux, 0 = plaintext ^ key0, 1 = round result
//   round_idx             : current round number, also selects the round key
//   mixcol_bypass         : skip MixColumns on the final round
//   busy                  : a block is in flight
//   out_valid / out_ready : ciphertext handshake towards the consumer
// Modport slave is the controller; modport master is its environment.
interface aes_round_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       reg_full;
    logic       reg_wr_en;
    logic       sel_input;
    logic [3:0] round_idx;
    logic       mixcol_bypass;
    logic       busy;
    logic       out_valid;
    logic       out_ready;

    modport slave (
        input  in_valid, reg_full, out_ready,
        output in_ready, reg_wr_en, sel_input, round_idx,
               mixcol_bypass, busy, out_valid
    );

    modport master (
        output in_valid, reg_full, out_ready,
        input  in_ready, reg_wr_en, sel_input, round_idx,
               mixcol_bypass, busy, out_valid
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencing controller for the 16-byte AES state register.
// Accepts one block, pulses the state-register write enable once for the
// initial AddRoundKey (LOAD) and once per round (ROUND), then holds the
// result until the consumer takes it (DONE).
// Ports:
//   clk    : single clock, rising edge
//   resetn : synchronous reset, active-high (1 = reset)
//   clear  : synchronous abort back to IDLE
//   bus    : handshake and datapath controls (see aes_round_ctrl_if)
// Parameters:
//   NR           : number of rounds, 1..15
//   ROUND_CYCLES : datapath latency per round in cycles, 1..16
module aes_round_ctrl #(
    parameter int NR           = 14,
    parameter int ROUND_CYCLES = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    aes_round_ctrl_if.slave   bus
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);
    localparam logic [3:0] WAIT_INIT  = 4'(ROUND_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_reg;
    logic [3:0] round_reg;
    logic [3:0] wait_reg;

    // Reset and abort share one path: both force the block away, so outputs
    // that would act on the datapath are suppressed in the same cycle.
    logic abort;
    assign abort = resetn | clear;

    always_ff @(posedge clk) begin
        if (abort) begin
            state_reg <= IDLE;
            round_reg <= 4'd0;
            wait_reg  <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_reg <= LOAD;
                        round_reg <= 4'd0;
                    end
                end
                LOAD: begin
                    state_reg <= ROUND;
                    round_reg <= 4'd1;
                    wait_reg  <= WAIT_INIT;
                end
                ROUND: begin
                    if (wait_reg != 4'd0) begin
                        wait_reg <= wait_reg - 4'd1;
                    end else if (round_reg < LAST_ROUND) begin
                        round_reg <= round_reg + 4'd1;
                        wait_reg  <= WAIT_INIT;
                    end else begin
                        // round_reg stays at NR through DONE
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (bus.reg_full && bus.out_ready) begin
                        state_reg <= IDLE;
                        round_reg <= 4'd0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    round_reg <= 4'd0;
                    wait_reg  <= 4'd0;
                end
            endcase
        end
    end

    // Outputs decoded from the registered state and counters.
    always_comb begin
        bus.in_ready      = (state_reg == IDLE) && !abort;
        bus.reg_wr_en     = 1'b0;
        bus.sel_input     = 1'b0;
        bus.mixcol_bypass = 1'b0;
        bus.out_valid     = 1'b0;
        if (!abort) begin
            case (state_reg)
                LOAD: begin
                    bus.reg_wr_en = 1'b1;
                end
                ROUND: begin
                    if (wait_reg == 4'd0) begin
                        bus.reg_wr_en     = 1'b1;
                        bus.sel_input     = 1'b1;
                        bus.mixcol_bypass = (round_reg == LAST_ROUND);
                    end
                end
                DONE: begin
                    bus.out_valid = bus.reg_full;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.round_idx = round_reg;
    assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: two instances (ROUND_CYCLES = 1 and 3) share one
// stimulus stream. Each instance has a schedule-based reference: on accept,
// every expected write pulse (absolute cycle, round, mux, bypass) is queued;
// a monitor pops and compares whenever the DUT is due to write, and checks
// the handshake outputs against the block's phase each cycle.
module tb_aes_round_ctrl;

    localparam int NR = 14;

    typedef struct {
        int cyc;
        int ridx;
        int sel;
        int byp;
    } ev_t;

    logic clk;
    logic resetn;
    logic clear;
    logic in_valid;
    logic reg_full;
    logic out_ready;

    int cyc;
    int tests;
    int fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int inst, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s inst%0d cyc %0d: got %0d expected %0d", name, inst, cyc, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int RC = (gi == 0) ? 1 : 3;

        aes_round_ctrl_if bus();

        assign bus.in_valid  = in_valid;
        assign bus.reg_full  = reg_full;
        assign bus.out_ready = out_ready;

        aes_round_ctrl #(
            .NR           (NR),
            .ROUND_CYCLES (RC)
        ) dut (
            .clk    (clk),
            .resetn (resetn),
            .clear  (clear),
            .bus    (bus.slave)
        );

        // phase: 0 idle, 1 block in flight, 2 result held
        ev_t q[$];
        int  phase;
        int  done_start;
        int  blocks;

        initial begin
            phase  = 0;
            blocks = 0;
            forever begin
                @(negedge clk);
                if (cyc > 0) begin
                    if (phase == 1 && cyc >= done_start) phase = 2;

                    check("busy", gi, int'(bus.busy), int'(phase != 0));
                    check("in_ready", gi, int'(bus.in_ready),
                          int'(phase == 0 && !clear && !resetn));
                    if (!resetn) begin
                        check("out_valid", gi, int'(bus.out_valid),
                              int'(phase == 2 && reg_full && !clear));
                    end
                    if (phase == 0 && !resetn) check("idle_round", gi, int'(bus.round_idx), 0);
                    if (phase == 2 && !resetn) check("done_round", gi, int'(bus.round_idx), NR);

                    if (q.size() > 0 && q[0].cyc == cyc && !clear && !resetn) begin
                        ev_t ev;
                        ev = q.pop_front();
                        check("wr_en", gi, int'(bus.reg_wr_en), 1);
                        check("round_idx", gi, int'(bus.round_idx), ev.ridx);
                        check("sel_input", gi, int'(bus.sel_input), ev.sel);
                        check("bypass", gi, int'(bus.mixcol_bypass), ev.byp);
                    end else if (!resetn) begin
                        check("wr_en_idle", gi, int'(bus.reg_wr_en), 0);
                    end

                    if (clear || resetn) begin
                        q.delete();
                        phase = 0;
                    end else if (phase == 0 && in_valid) begin
                        // Accept lands on the next edge, numbered cyc+1.
                        for (int r = 0; r <= NR; r++) begin
                            ev_t e;
                            e.cyc  = cyc + 1 + r * RC;
                            e.ridx = r;
                            e.sel  = (r != 0) ? 1 : 0;
                            e.byp  = (r == NR) ? 1 : 0;
                            q.push_back(e);
                        end
                        done_start = cyc + 2 + NR * RC;
                        phase = 1;
                    end else if (phase == 2 && reg_full && out_ready) begin
                        blocks++;
                        $display("[TB] inst%0d (ROUND_CYCLES=%0d) block %0d delivered at cyc %0d",
                                 gi, RC, blocks, cyc);
                        phase = 0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_round0(input int r);
        int found;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (int'(g_inst[0].bus.round_idx) == r && g_inst[0].bus.reg_wr_en) found = 1;
            else step();
        end
        check("wait_round", 0, found, 1);
    endtask

    task automatic wait_out_valid0();
        int found;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (g_inst[0].bus.out_valid) found = 1;
            else step();
        end
        check("wait_out_valid", 0, found, 1);
    endtask

    initial begin
        cyc       = 0;
        tests     = 0;
        fails     = 0;
        resetn    = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b1;
        reg_full  = 1'b1;
        out_ready = 1'b1;
        #1;
        step();
        step();
        resetn = 1'b0;

        // Nominal back-to-back blocks.
        repeat (80) step();

        // Back-pressure in DONE.
        out_ready = 1'b0;
        wait_out_valid0();
        repeat (5) step();
        out_ready = 1'b1;
        repeat (40) step();

        // Register not full in DONE.
        reg_full = 1'b0;
        repeat (70) step();
        reg_full = 1'b1;
        repeat (20) step();

        // Abort at round 7, then a fresh block runs to completion.
        wait_round0(7);
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (60) step();

        // Reset in the middle of round 5.
        wait_round0(5);
        resetn = 1'b1;
        step();
        resetn = 1'b0;
        repeat (60) step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 79) == 0);
            resetn    = ($urandom_range(0, 399) == 0);
            reg_full  = ($urandom_range(0, 5) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Drain.
        in_valid  = 1'b0;
        clear     = 1'b0;
        resetn    = 1'b0;
        reg_full  = 1'b1;
        out_ready = 1'b1;
        repeat (100) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Sequencing controller for the 16-byte AES state register, with 8-bit lanes and a 16-lane vector. It accepts a plaintext block through a valid/ready handshake and loads it into the state register with the initial AddRoundKey. It then steps the datapath through NR rounds by pulsing the register write enable, and presents the finished block through an output valid/ready handshake. It sits between the core's input interface and the state register / round-function datapath, and drives the datapath mux select, round index and MixColumns bypass.

Parameters:
NR, 14, number of AES rounds (14 for AES-256); legal range 1..15
ROUND_CYCLES, 1, datapath latency per round in clock cycles; legal range 1..16

Ports:
clk  input  1  single clock, rising edge
resetn  input  1  synchronous reset, active-high (asserted = 1); sampled on rising clk edge
clear  input  1  synchronous abort; returns the block to IDLE
in_valid  input  1  plaintext block available on the datapath input
in_ready  output  1  controller accepts a block this cycle
reg_full  input  1  full flag from the state register (1 = register holds a written block)
reg_wr_en  output  1  state register write enable, single-cycle pulses
sel_input  output  1  datapath mux select: 0 = plaintext plus round key 0, 1 = round-function result
round_idx  output  4  current round number; also selects the round key
mixcol_bypass  output  1  skip MixColumns (final round)
busy  output  1  block in flight (any state except IDLE)
out_valid  output  1  ciphertext in the state register is valid
out_ready  input  1  downstream consumes the ciphertext

Behaviour:
- States: IDLE, LOAD, ROUND, DONE. Registered state; outputs are decoded from the state and counters.
- Reset (resetn=1 at an edge): next state IDLE, round_idx=0, wait counter=0.
  - All outputs 0 while in IDLE, except in_ready.
  - Reset overrides every other input, including mid-round and during DONE.
- IDLE:
  - in_ready = !clear.
  - Accept on in_valid && in_ready → LOAD. No other transition.
- LOAD: exactly one cycle.
  - reg_wr_en=1, sel_input=0, round_idx=0, mixcol_bypass=0.
  - Next state ROUND with round_idx=1 and wait counter=ROUND_CYCLES-1.
- ROUND:
  - While the wait counter is nonzero: decrement it, reg_wr_en=0.
  - When the counter is 0: reg_wr_en=1, sel_input=1, mixcol_bypass=(round_idx==NR).
  - If round_idx<NR: increment round_idx and reload the counter to ROUND_CYCLES-1.
  - Otherwise go to DONE.
- DONE:
  - out_valid = reg_full; round_idx holds NR; reg_wr_en=0.
  - On out_valid && out_ready → IDLE with round_idx=0.
  - If reg_full=0 in DONE, out_valid stays low and the FSM waits; there is no timeout.
- Latency:
  - Input accepted at edge T: LOAD write at T+1; round r write at T+1+r*ROUND_CYCLES; out_valid at T+2+NR*ROUND_CYCLES.
  - Defaults: out_valid 16 cycles after acceptance; 15 write pulses total.
- in_ready is 0 in every non-IDLE state, including DONE. No overlap of blocks; the next block is accepted one cycle after the output handshake at the earliest.
- clear (synchronous):
  - From any state, next state is IDLE with round_idx=0 and no reg_wr_en that cycle.
  - clear beats in_valid in IDLE (in_ready=0).
  - clear in DONE drops out_valid without a handshake.
- out_valid must not drop without out_ready, except on clear or reset.
- round_idx never exceeds NR and never wraps.
- busy = (state != IDLE).

Test Plan:
- Reset: resetn=1 for 2 cycles with in_valid=1 → in_ready=0 during reset, then 1; all other outputs 0; round_idx=0.
- Nominal (NR=14, ROUND_CYCLES=1, reg_full=1, out_ready=1), accept at edge T:
  - reg_wr_en high for cycles T+1..T+15, with round_idx 0..14.
  - sel_input=0 only at T+1; mixcol_bypass=1 only at T+15.
  - out_valid at T+16; IDLE at T+17.
- Back-pressure: out_ready=0 for 5 cycles in DONE → out_valid held 1, round_idx=14, in_ready=0, no reg_wr_en. Then out_ready=1 → IDLE next cycle.
- ROUND_CYCLES=3: write pulses are spaced exactly 3 cycles apart after LOAD; out_valid at T+44.
- Abort: clear=1 at round 7 → IDLE next cycle, no further reg_wr_en, round_idx=0. A new block is then accepted and completes normally.
- reg_full=0 in DONE → out_valid=0 until reg_full=1. Reset asserted mid-round 5 → IDLE, outputs cleared on the next edge.
